// File: rtl/mem_port_arbiter.sv
// Shares one cacheline adaptor port between the I-cache and the D-cache.
// One line transaction at a time; ties alternate so neither side starves.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [1:0]            owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  d_req;
    logic                  pick_d;

    assign d_req  = d_read | d_write;
    // Data wins unless instr is also asking and data was served last.
    assign pick_d = d_req & (~i_read | ~last_grant_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d      = GRANT_D;
                    last_grant_d = 1'b1;
                    addr_d       = d_addr;
                    wdata_d      = d_wdata;
                    write_d      = d_write;
                end else if (i_read) begin
                    state_d      = GRANT_I;
                    last_grant_d = 1'b0;
                    addr_d       = i_addr;
                    write_d      = 1'b0;
                end
            end
            GRANT_I: begin
                if (pmem_resp) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            GRANT_D: begin
                if (pmem_resp) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pmem_read  = (state_q != IDLE) & ~write_q;
    assign pmem_write = (state_q != IDLE) & write_q;
    assign pmem_addr  = addr_q;
    assign pmem_wdata = wdata_q;
    assign i_rdata    = pmem_rdata;
    assign d_rdata    = pmem_rdata;
    assign owner      = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with an adaptor/memory
// model and a busy/owner reference model of the arbitration rules.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;
    logic [1:0]    owner;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .owner(owner)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit            chk;
        logic [LW-1:0] data;
    } exp_t;

    exp_t          i_exp[$];
    exp_t          d_exp[$];
    exp_t          ie, de;
    logic [LW-1:0] mem  [logic [AW-1:0]];
    logic [LW-1:0] dref [logic [AW-1:0]];
    bit            ad_hold = 1'b0;

    function automatic exp_t mk(input bit c, input logic [LW-1:0] d);
        exp_t e;
        e.chk  = c;
        e.data = d;
        return e;
    endfunction

    function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_0F0F}};
    endfunction

    function automatic logic [LW-1:0] i_ref(input logic [AW-1:0] a);
        return (a == 32'h60) ? {32{8'hAA}} : init_line(a);
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act,
                         input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one transaction in flight, latched at grant.
    bit            m_busy, m_port, m_last, m_write;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b0;
        end else if (!m_busy) begin
            if (i_read && (d_read || d_write)) m_port = ~m_last;
            else m_port = d_read || d_write;
            if (i_read || d_read || d_write) begin
                m_busy  = 1'b1;
                m_last  = m_port;
                m_addr  = m_port ? d_addr : i_addr;
                m_write = m_port && d_write;
                if (m_port) m_wdata = d_wdata;
            end
        end else if (pmem_resp) begin
            m_busy = 1'b0;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            check("owner", owner, m_busy ? (m_port ? 2'b10 : 2'b01) : 2'b00);
            check("pmem_read", pmem_read, m_busy && !m_write);
            check("pmem_write", pmem_write, m_busy && m_write);
            if (m_busy) check("pmem_addr", pmem_addr, m_addr);
            if (m_busy && m_write) check("pmem_wdata", pmem_wdata, m_wdata);
            check("i_resp", i_resp, m_busy && !m_port && pmem_resp);
            check("d_resp", d_resp, m_busy && m_port && pmem_resp);
            check("d_rdata_pass", d_rdata, pmem_rdata);
            if (i_resp) begin
                if (i_exp.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL i_sb: i_resp got 1 expected no pending request");
                end else begin
                    ie = i_exp.pop_front();
                    check("i_sb_data", i_rdata, ie.data);
                end
            end
            if (d_resp) begin
                if (d_exp.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL d_sb: d_resp got 1 expected no pending request");
                end else begin
                    de = d_exp.pop_front();
                    if (de.chk) check("d_sb_data", d_rdata, de.data);
                end
            end
        end
    end

    // Cacheline adaptor model with random latency and stray idle pulses.
    initial begin
        bit busy;
        int wt;
        busy = 1'b0;
        wt = 0;
        mem[32'h60] = {32{8'hAA}};
        forever begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (rst || ad_hold) begin
                busy = 1'b0;
                continue;
            end
            if (!busy && (pmem_read || pmem_write)) begin
                busy = 1'b1;
                wt = $urandom_range(0, 4);
            end
            if (busy) begin
                if (wt == 0) begin
                    pmem_resp = 1'b1;
                    busy = 1'b0;
                    if (pmem_write) begin
                        mem[pmem_addr] = pmem_wdata;
                        pmem_rdata = rand_line();
                    end else begin
                        pmem_rdata = mem.exists(pmem_addr) ? mem[pmem_addr]
                                                           : init_line(pmem_addr);
                    end
                end else begin
                    wt--;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                pmem_resp = 1'b1;
                pmem_rdata = rand_line();
            end
        end
    end

    task automatic i_driver(input int n);
        for (int k = 0; k < n; k++) begin
            logic [AW-1:0] a;
            bit got, dropped, r, own;
            got = 1'b0;
            dropped = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            a = AW'($urandom_range(0, 63)) << 5;
            i_addr = a;
            i_read = 1'b1;
            i_exp.push_back(mk(1'b1, i_ref(a)));
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                r = i_resp;
                own = (owner == 2'b01);
                @(posedge clk); #1;
                if (r) got = 1'b1;
                else if (own && !dropped && $urandom_range(0, 3) == 0) begin
                    dropped = 1'b1;
                    i_read = 1'b0;
                    i_addr = $urandom;
                end
            end
            i_read = 1'b0;
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL i_timeout: got no i_resp expected one for %h", a);
            end
        end
    endtask

    task automatic d_driver(input int n);
        for (int k = 0; k < n; k++) begin
            logic [AW-1:0] a;
            logic [LW-1:0] w;
            bit got, dropped, r, own;
            got = 1'b0;
            dropped = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            a = 32'h0001_0000 | (AW'($urandom_range(0, 15)) << 5);
            w = rand_line();
            d_addr = a;
            d_wdata = w;
            if ($urandom_range(0, 2) == 0) begin
                dref[a] = w;
                d_write = 1'b1;
                d_read = ($urandom_range(0, 3) == 0);
                d_exp.push_back(mk(1'b0, '0));
            end else begin
                d_read = 1'b1;
                d_exp.push_back(mk(1'b1, dref.exists(a) ? dref[a] : init_line(a)));
            end
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                r = d_resp;
                own = (owner == 2'b10);
                @(posedge clk); #1;
                if (r) got = 1'b1;
                else if (own && !dropped && $urandom_range(0, 3) == 0) begin
                    dropped = 1'b1;
                    d_read = 1'b0;
                    d_write = 1'b0;
                    d_addr = $urandom;
                    d_wdata = rand_line();
                end
            end
            d_read = 1'b0;
            d_write = 1'b0;
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL d_timeout: got no d_resp expected one for %h", a);
            end
        end
    endtask

    task automatic serve_both();
        bit gi, gd, ri, rd;
        gi = 1'b0;
        gd = 1'b0;
        for (int c = 0; c < 100 && !(gi && gd); c++) begin
            @(negedge clk);
            ri = i_resp;
            rd = d_resp;
            @(posedge clk); #1;
            if (ri) begin gi = 1'b1; i_read = 1'b0; end
            if (rd) begin gd = 1'b1; d_read = 1'b0; end
        end
        check("tie_both_served", {gi, gd}, 2'b11);
    endtask

    initial begin
        int to;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk); #1;
        check("rst_pmem_addr", pmem_addr, '0);
        check("rst_pmem_wdata", pmem_wdata, '0);
        repeat (10) @(posedge clk);
        #1;
        // Reset in the middle of an instruction grant.
        ad_hold = 1'b1;
        i_addr = 32'h60;
        i_read = 1'b1;
        i_exp.push_back(mk(1'b1, i_ref(32'h60)));
        to = 0;
        do begin
            @(negedge clk);
            to++;
        end while (owner != 2'b01 && to < 10);
        check("grant_i_seen", owner, 2'b01);
        #2 rst = 1'b1;
        #1;
        check("async_owner", owner, 2'b00);
        check("async_pmem_read", pmem_read, 1'b0);
        check("async_pmem_write", pmem_write, 1'b0);
        check("async_i_resp", i_resp, 1'b0);
        i_read = 1'b0;
        i_exp.delete();
        @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        ad_hold = 1'b0;
        @(posedge clk); #1;
        // Re-issue plus a simultaneous data read: data must win first.
        i_addr = 32'h60;
        i_read = 1'b1;
        i_exp.push_back(mk(1'b1, i_ref(32'h60)));
        d_addr = 32'h0001_0040;
        d_read = 1'b1;
        d_exp.push_back(mk(1'b1, init_line(32'h0001_0040)));
        serve_both();
        fork
            i_driver(150);
            d_driver(150);
        join
        repeat (5) @(posedge clk);
        #1;
        check("i_sb_empty", i_exp.size(), 0);
        check("d_sb_empty", d_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one physical memory line port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two caches and the cacheline adaptor. It sequences one line transaction at a time so that the IF-stage and MEM-stage misses share main memory without collision.
- Uses a round-robin tie-break so neither requester starves. Requests are latched at grant.

Parameters:
- ADDR_WIDTH, 32, byte address width of all address ports.
- LINE_WIDTH, 256, cache line width in bits.

Ports:
- clk  in  1  system clock. Single clock domain, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_read  in  1  instruction cache line read request.
- i_addr  in  ADDR_WIDTH  instruction line address (line aligned).
- i_rdata  out  LINE_WIDTH  line returned to instruction cache.
- i_resp  out  1  one-cycle completion pulse to instruction cache.
- d_read  in  1  data cache line read request.
- d_write  in  1  data cache line write-back request.
- d_addr  in  ADDR_WIDTH  data line address.
- d_wdata  in  LINE_WIDTH  write-back line.
- d_rdata  out  LINE_WIDTH  line returned to data cache.
- d_resp  out  1  one-cycle completion pulse to data cache.
- pmem_read  out  1  read strobe to cacheline adaptor.
- pmem_write  out  1  write strobe to cacheline adaptor.
- pmem_addr  out  ADDR_WIDTH  transaction address.
- pmem_wdata  out  LINE_WIDTH  transaction write line.
- pmem_rdata  in  LINE_WIDTH  line from adaptor.
- pmem_resp  in  1  adaptor completion pulse.
- owner  out  2  current grant: 00 none, 01 instr, 10 data.

Behaviour:
- States: IDLE, GRANT_I, GRANT_D.
- Also holds:
  - last_grant flag: 0 = instr, 1 = data.
  - Latched registers: addr_q, wdata_q, write_q.
- Reset (async, rst=1):
  - state=IDLE, last_grant=0, addr_q=0, wdata_q=0, write_q=0.
  - pmem_read=0, pmem_write=0, pmem_addr=0, pmem_wdata=0, owner=00, i_resp=0, d_resp=0.
- IDLE, choosing a grant:
  - d_req = d_read|d_write; i_req = i_read.
  - Only one of them high: grant that one.
  - Both high: grant the one NOT in last_grant. After reset the first tie therefore goes to data.
  - On the grant edge:
    - Latch the address, and for data also d_wdata.
    - write_q = d_write (d_write wins if d_read and d_write are both high).
    - Update last_grant.
    - Next state GRANT_I or GRANT_D.
- pmem_* are registered outputs:
  - pmem_read = grant active and !write_q; pmem_write = grant active and write_q.
  - pmem_addr = addr_q; pmem_wdata = wdata_q.
  - Latency: request sampled at edge N; pmem strobe is high from cycle N+1.
- GRANT_x:
  - Hold the pmem strobes and the latched values stable until pmem_resp.
  - In the cycle pmem_resp=1: x_resp=1 combinationally, with x_rdata = pmem_rdata.
  - Next state is IDLE; strobes are low in the following cycle.
- Response routing:
  - i_rdata and d_rdata always pass through pmem_rdata.
  - The resp of the non-owner is 0.
- Requester contract: a requester holds its request and inputs stable until it sees resp, and deasserts by the next cycle.
- Minimum of one IDLE cycle between consecutive grants. Back-to-back transactions are spaced by at least one turnaround cycle.
- Boundary conditions:
  - A request deasserted during its own grant is ignored. The transaction completes on the latched values and resp still pulses.
  - pmem_resp in IDLE is ignored: no resp output, no state change.
  - Request changes during a grant do not alter pmem_addr or pmem_wdata.
  - Async reset mid-transaction returns to IDLE immediately and drops strobes. The adaptor is reset on the same rst.
- owner mirrors the state: IDLE=00, GRANT_I=01, GRANT_D=10.

Test Plan:
- Reset release, no requests -> all strobes 0, owner=00, state stays IDLE for 10 cycles.
- i_read=1, i_addr=0x0000_0060 at edge N, pmem_resp after 4 cycles with rdata=0xAA..AA:
  - pmem_read=1 and pmem_addr=0x60 from N+1.
  - i_resp=1 for exactly one cycle with i_rdata=0xAA..AA.
  - d_resp stays 0.
- d_write=1, d_addr=0x100, d_wdata=0x1234..:
  - pmem_write=1, pmem_read=0, pmem_wdata=0x1234.. held stable until pmem_resp.
  - Then d_resp pulse and owner returns to 00.
- Both i_read and d_read asserted together right after reset, requests held:
  - Data granted first.
  - After its resp and one IDLE cycle, instruction is granted.
  - A second simultaneous tie then goes to instruction.
- During GRANT_D, change d_addr to 0x200 and drop d_read -> pmem_addr stays at the original value and d_resp still pulses on pmem_resp.
- Assert rst for one cycle mid GRANT_I -> strobes and owner go 0 asynchronously, no i_resp. After release, a re-issued request is served normally.
